rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Four-requester round-robin arbiter that shares one 32-bit 4:1 data path between independent sources. It drives the 2-bit select of that path, captures the winning source's word into a one-entry output register, and presents it downstream with a valid/ready handshake. It sits in front of any shared 32-bit sink, such as a register-file write port or a memory bus, where several datapath units compete for a single slot per cycle.

## Interface
- WIDTH, 32, data word width of d0..d3 and out.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-source request; req[i] means d_i is valid and held stable until gnt[i].
- d0, d1, d2, d3  input  WIDTH  source data words.
- gnt  output  4  one-hot grant. Combinational, asserted in the capture cycle only.
- select  output  2  registered index of the last captured source; drives the shared mux select.
- out  output  WIDTH  registered captured word.
- out_valid  output  1  out holds an undelivered word.
- out_ready  input  1  sink accepts out this cycle.

## Operation
- Two-state FSM:
  - IDLE: output register empty, out_valid=0.
  - HOLD: output register full, out_valid=1.
- load = (state==IDLE) | (state==HOLD & out_ready).
- Winner w is the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- capture = load & (req != 0).
- On capture:
  - gnt[w]=1 in the same cycle.
  - At the edge: out<=d_w, select<=w, ptr<=(w+1) mod 4, state->HOLD.
- Transitions without capture:
  - HOLD & out_ready & req==0 -> IDLE, out_valid<=0.
  - HOLD & !out_ready -> stay in HOLD. out, select and ptr hold; gnt=0.
- IDLE with req==0: no change. out and select keep their last values.
- gnt is always one-hot or zero and is never asserted when capture=0.
- Requester rule: keep req[i] and d_i stable until the cycle gnt[i]=1. The requester may drop req[i], or present a new word, from the next cycle. A request withdrawn before its grant is legal and is simply skipped.
- ptr is a 2-bit counter. Wrap-around is 3 -> 0.
- Fairness: a continuously asserted request is granted within 4 captures.

## Timing
- Reset values (rst_n low, asynchronous): state=IDLE, out=0, out_valid=0, select=2'b00, ptr=2'b00, gnt=4'b0000 (forced while rst_n is low).
- Reset mid-operation:
  - Any undelivered word is discarded.
  - Pending requests are re-arbitrated from ptr=0 starting at the first rising edge after rst_n rises.
- Latency: request sampled in cycle n produces gnt in cycle n. out, select and out_valid update after the edge ending cycle n.
- Throughput: one word per cycle while out_ready=1 and at least one request is pending. There are no bubbles.
- Simultaneous events:
  - In HOLD with out_ready=1, delivery of the old word and capture of a new word occur on the same edge. out_valid stays 1.
- Backpressure:
  - out_ready is ignored while out_valid=0.
  - While out_valid=1 & out_ready=0, out and select are stable cycle to cycle.

## Test plan
- Reset: rst_n=0 mid-HOLD with out=32'hDEADBEEF -> out=0, out_valid=0, select=0 and gnt=0 immediately, without waiting for a clock edge.
- Single source: req=4'b0100, d2=32'h0000_00A5, out_ready=1 -> gnt=4'b0100 in the same cycle; next cycle out=32'h0000_00A5, select=2, out_valid=1.
- Round robin: req=4'b1111 held, out_ready=1, starting from ptr=0 -> grant sequence 0,1,2,3,0 on consecutive cycles; select follows 0,1,2,3,0.
- Wrap and skip: ptr=3, req=4'b0101 -> d0 granted first, then d2, then d0.
- Backpressure: HOLD with out=32'h1234_5678, out_ready=0 for 3 cycles and req=4'b0010 -> gnt=0 and out stable for 3 cycles; d1 is captured on the cycle out_ready=1.
- Drain: HOLD, out_ready=1, req=0 -> out_valid=0 next cycle and state=IDLE; out and select keep their last values.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter feeding a shared 32-bit 4:1 path into a
// one-entry output register with valid/ready handshake toward the sink.
module rr_mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic             capture;
  logic [WIDTH-1:0] mux_word;
  logic [WIDTH-1:0] out_nxt;
  logic [1:0]       select_nxt;

  // Scan starts at ptr so the source after the last winner has top priority.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    mux_word = d0;
    case (win)
      2'd0: mux_word = d0;
      2'd1: mux_word = d1;
      2'd2: mux_word = d2;
      2'd3: mux_word = d3;
      default: mux_word = d0;
    endcase
  end

  assign load      = (state == IDLE) || out_ready;
  assign capture   = load && (req != 4'b0000);
  assign out_valid = (state == HOLD);

  // Grant is combinational, so it is gated directly by rst_n to stay low in reset.
  assign gnt = (capture && rst_n) ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    out_nxt    = out;
    select_nxt = select;
    if (capture) begin
      state_nxt  = HOLD;
      ptr_nxt    = win + 2'd1;
      out_nxt    = mux_word;
      select_nxt = win;
    end else if (state == HOLD && out_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      out    <= '0;
      select <= 2'd0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      out    <= out_nxt;
      select <= select_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: inputs change on the falling edge and
// outputs are compared mid-cycle against hand-computed values.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] dv [4];
  logic [3:0]  gnt;
  logic [1:0]  select;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  rr_mux_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (dv[0]),
    .d1        (dv[1]),
    .d2        (dv[2]),
    .d3        (dv[3]),
    .gnt       (gnt),
    .select    (select),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = 32'h0;

    // Reset state
    #3;
    check("rst_out", out, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_select", {30'b0, select}, 32'h0);
    check("rst_gnt", {28'b0, gnt}, 32'h0);
    req = 4'b0001;
    #1 check("rst_gnt_forced", {28'b0, gnt}, 32'h0);

    // Single source
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req       = 4'b0100;
    dv[2]     = 32'h0000_00A5;
    out_ready = 1'b1;
    #1 check("single_gnt", {28'b0, gnt}, 32'h4);
    @(negedge clk);
    check("single_out", out, 32'h0000_00A5);
    check("single_select", {30'b0, select}, 32'h2);
    check("single_valid", {31'b0, out_valid}, 32'h1);

    // Drain
    req = 4'b0000;
    #1 check("drain_gnt", {28'b0, gnt}, 32'h0);
    @(negedge clk);
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    check("drain_out_kept", out, 32'h0000_00A5);
    check("drain_select_kept", {30'b0, select}, 32'h2);

    // Wrap and skip, ptr=3
    req   = 4'b0101;
    dv[0] = 32'h1111_0000;
    dv[2] = 32'h2222_0000;
    #1 check("wrap_gnt0", {28'b0, gnt}, 32'h1);
    @(negedge clk);
    check("wrap_out0", out, 32'h1111_0000);
    check("wrap_sel0", {30'b0, select}, 32'h0);
    #1 check("wrap_gnt2", {28'b0, gnt}, 32'h4);
    @(negedge clk);
    check("wrap_out2", out, 32'h2222_0000);
    check("wrap_sel2", {30'b0, select}, 32'h2);
    dv[0] = 32'h1234_5678;
    #1 check("wrap_gnt0b", {28'b0, gnt}, 32'h1);
    @(negedge clk);
    check("wrap_out0b", out, 32'h1234_5678);
    check("wrap_sel0b", {30'b0, select}, 32'h0);

    // Backpressure for 3 cycles, then d1 captured
    out_ready = 1'b0;
    req       = 4'b0010;
    dv[1]     = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_gnt", {28'b0, gnt}, 32'h0);
      check("bp_out", out, 32'h1234_5678);
      check("bp_select", {30'b0, select}, 32'h0);
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_gnt", {28'b0, gnt}, 32'h2);
    @(negedge clk);
    check("bp_release_out", out, 32'hCAFE_0001);
    check("bp_release_sel", {30'b0, select}, 32'h1);
    check("bp_release_valid", {31'b0, out_valid}, 32'h1);

    // Load DEADBEEF, then reset mid-HOLD
    req   = 4'b1000;
    dv[3] = 32'hDEAD_BEEF;
    #1 check("pre_rst_gnt", {28'b0, gnt}, 32'h8);
    @(negedge clk);
    check("pre_rst_out", out, 32'hDEAD_BEEF);
    check("pre_rst_sel", {30'b0, select}, 32'h3);
    out_ready = 1'b0;
    req       = 4'b1111;
    #1 check("hold_noready_gnt", {28'b0, gnt}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out", out, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_select", {30'b0, select}, 32'h0);
    check("midrst_gnt", {28'b0, gnt}, 32'h0);

    // Round robin from ptr=0 with all requests held
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    dv[0] = 32'hA000_0000;
    dv[1] = 32'hA000_0001;
    dv[2] = 32'hA000_0002;
    dv[3] = 32'hA000_0003;
    for (int k = 0; k < 5; k++) begin
      #1 check("rr_gnt", {28'b0, gnt}, 32'h1 << (k % 4));
      @(negedge clk);
      check("rr_select", {30'b0, select}, 32'(k % 4));
      check("rr_out", out, 32'hA000_0000 + 32'(k % 4));
      check("rr_valid", {31'b0, out_valid}, 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
